// File: rtl/axi_burst_master_if.sv
// axi_burst_master_if: bundles the client command/data-stream signals and the
// AXI4 AW/W/B/AR/R channel signals of axi_burst_master.
//   master modport : view of the burst master (drives AXI requests, client responses)
//   slave modport  : view of the client plus the memory responder
interface axi_burst_master_if #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDRESS_WIDTH = 64,
  parameter int unsigned ID_WIDTH      = 1
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // client command / data stream
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_write;
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic [7:0]               cmd_len;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     wr_valid;
  logic                     wr_ready;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_valid;
  logic                     rd_last;
  logic                     rd_ready;
  logic                     done;
  logic [1:0]               done_resp;

  // AXI write address
  logic [ID_WIDTH-1:0]      aw_id;
  logic [ADDRESS_WIDTH-1:0] aw_addr;
  logic [7:0]               aw_len;
  logic [2:0]               aw_size;
  logic [1:0]               aw_burst;
  logic [3:0]               aw_cache;
  logic [2:0]               aw_prot;
  logic [3:0]               aw_qos;
  logic [3:0]               aw_region;
  logic                     aw_valid;
  logic                     aw_ready;

  // AXI write data / response
  logic [DATA_WIDTH-1:0]    w_data;
  logic [STRB_WIDTH-1:0]    w_strb;
  logic                     w_last;
  logic                     w_valid;
  logic                     w_ready;
  logic [1:0]               b_resp;
  logic [ID_WIDTH-1:0]      b_id;
  logic                     b_valid;
  logic                     b_ready;

  // AXI read address
  logic [ID_WIDTH-1:0]      ar_id;
  logic [ADDRESS_WIDTH-1:0] ar_addr;
  logic [7:0]               ar_len;
  logic [2:0]               ar_size;
  logic [1:0]               ar_burst;
  logic [3:0]               ar_cache;
  logic [2:0]               ar_prot;
  logic [3:0]               ar_qos;
  logic [3:0]               ar_region;
  logic                     ar_valid;
  logic                     ar_ready;

  // AXI read data
  logic [ID_WIDTH-1:0]      r_id;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [1:0]               r_resp;
  logic                     r_last;
  logic                     r_valid;
  logic                     r_ready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
           aw_ready, w_ready, b_resp, b_id, b_valid, ar_ready,
           r_id, r_data, r_resp, r_last, r_valid,
    output cmd_ready, wr_ready, rd_data, rd_valid, rd_last, done, done_resp,
           aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_cache, aw_prot, aw_qos,
           aw_region, aw_valid, w_data, w_strb, w_last, w_valid, b_ready,
           ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_cache, ar_prot, ar_qos,
           ar_region, ar_valid, r_ready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
           aw_ready, w_ready, b_resp, b_id, b_valid, ar_ready,
           r_id, r_data, r_resp, r_last, r_valid,
    input  cmd_ready, wr_ready, rd_data, rd_valid, rd_last, done, done_resp,
           aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_cache, aw_prot, aw_qos,
           aw_region, aw_valid, w_data, w_strb, w_last, w_valid, b_ready,
           ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_cache, ar_prot, ar_qos,
           ar_region, ar_valid, r_ready
  );
endinterface

// File: rtl/axi_burst_master.sv
// axi_burst_master: AXI4 initiator issuing one INCR burst per client command,
// a write over AW/W/B or a read over AR/R, one transaction outstanding.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - axi_burst_master_if.master: client command, write/read beat streams,
//          done/done_resp completion pulse, and all AXI4 channel signals
// Optional feature: define AXI_BURST_MASTER_TIMEOUT_EN to enable a watchdog that
// forces completion with done_resp=2'b11 after TIMEOUT cycles without a handshake.
module axi_burst_master #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDRESS_WIDTH = 64,
  parameter int unsigned ID_WIDTH      = 1,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_burst_master_if.master   bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned AX_SIZE    = $clog2(STRB_WIDTH);

  typedef enum logic [2:0] {IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, DONE} state_t;

  state_t                   r_state, w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [7:0]               r_len, w_len_nxt;
  logic [8:0]               r_beat, w_beat_nxt;
  logic [1:0]               r_resp, w_resp_nxt;

  logic w_last_beat, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_any_hs, w_busy;
  logic [1:0] w_rd_acc;
  logic w_unused_ok;

  // r_id is not checked; TIMEOUT is only consumed by the watchdog build
  assign w_unused_ok = ^{bus.r_id, 1'(TIMEOUT)};

  assign w_last_beat = (r_beat == {1'b0, r_len});
  assign w_aw_hs  = (r_state == WR_AW) && bus.aw_ready;
  assign w_w_hs   = (r_state == WR_W)  && bus.wr_valid && bus.w_ready;
  assign w_b_hs   = (r_state == WR_B)  && bus.b_valid;
  assign w_ar_hs  = (r_state == RD_AR) && bus.ar_ready;
  assign w_r_hs   = (r_state == RD_R)  && bus.r_valid && bus.rd_ready;
  assign w_any_hs = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;
  assign w_busy   = (r_state != IDLE) && (r_state != DONE);

  // read response merge: worst of accumulated and current beat
  assign w_rd_acc = (bus.r_resp > r_resp) ? bus.r_resp : r_resp;

  // state and latched command registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_resp  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_len   <= w_len_nxt;
      r_beat  <= w_beat_nxt;
      r_resp  <= w_resp_nxt;
    end
  end

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             w_tmo_hit;

  // watchdog: counts idle-handshake cycles while a transaction is in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_tmo <= '0;
    else if (w_busy && !w_any_hs) r_tmo <= r_tmo + TMO_W'(1);
    else                       r_tmo <= '0;
  end
  assign w_tmo_hit = w_busy && !w_any_hs && (r_tmo == TMO_W'(TIMEOUT - 1));
`endif

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_len_nxt   = r_len;
    w_beat_nxt  = r_beat;
    w_resp_nxt  = r_resp;
    case (r_state)
      IDLE: if (bus.cmd_valid) begin
        w_addr_nxt  = bus.cmd_addr;
        w_len_nxt   = bus.cmd_len;
        w_state_nxt = bus.cmd_write ? WR_AW : RD_AR;
      end
      WR_AW: if (w_aw_hs) begin
        w_beat_nxt  = '0;
        w_resp_nxt  = '0;
        w_state_nxt = WR_W;
      end
      WR_W: if (w_w_hs) begin
        w_beat_nxt = r_beat + 9'd1;
        if (w_last_beat) w_state_nxt = WR_B;
      end
      WR_B: if (w_b_hs) begin
        w_resp_nxt  = (bus.b_id != '0) ? 2'b10 : bus.b_resp;
        w_state_nxt = DONE;
      end
      RD_AR: if (w_ar_hs) begin
        w_beat_nxt  = '0;
        w_resp_nxt  = '0;
        w_state_nxt = RD_R;
      end
      RD_R: if (w_r_hs) begin
        w_beat_nxt = r_beat + 9'd1;
        w_resp_nxt = w_rd_acc;
        // slave's last flag disagrees with the requested length
        if ((bus.r_last != w_last_beat) && (w_rd_acc < 2'b10)) w_resp_nxt = 2'b10;
        if (bus.r_last || w_last_beat) w_state_nxt = DONE;
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
    if (w_tmo_hit) begin
      w_state_nxt = DONE;
      w_resp_nxt  = 2'b11;
    end
`endif
  end

  // client side
  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.wr_ready  = (r_state == WR_W) && bus.w_ready;
  assign bus.rd_valid  = (r_state == RD_R) && bus.r_valid;
  assign bus.rd_last   = (r_state == RD_R) && bus.r_last;
  assign bus.rd_data   = bus.r_data;
  assign bus.done      = (r_state == DONE);
  assign bus.done_resp = r_resp;

  // write channels
  assign bus.aw_id     = '0;
  assign bus.aw_addr   = r_addr;
  assign bus.aw_len    = r_len;
  assign bus.aw_size   = 3'(AX_SIZE);
  assign bus.aw_burst  = 2'b01;
  assign bus.aw_cache  = 4'b0011;
  assign bus.aw_prot   = '0;
  assign bus.aw_qos    = '0;
  assign bus.aw_region = '0;
  assign bus.aw_valid  = (r_state == WR_AW);
  assign bus.w_data    = bus.wr_data;
  assign bus.w_strb    = '1;
  assign bus.w_last    = (r_state == WR_W) && w_last_beat;
  assign bus.w_valid   = (r_state == WR_W) && bus.wr_valid;
  assign bus.b_ready   = (r_state == WR_B);

  // read channels
  assign bus.ar_id     = '0;
  assign bus.ar_addr   = r_addr;
  assign bus.ar_len    = r_len;
  assign bus.ar_size   = 3'(AX_SIZE);
  assign bus.ar_burst  = 2'b01;
  assign bus.ar_cache  = 4'b0011;
  assign bus.ar_prot   = '0;
  assign bus.ar_qos    = '0;
  assign bus.ar_region = '0;
  assign bus.ar_valid  = (r_state == RD_AR);
  assign bus.r_ready   = (r_state == RD_R) && bus.rd_ready;
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed self-checking bench for axi_burst_master
// (default build, watchdog disabled).
module tb_axi_burst_master;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad   = 0;

  axi_burst_master_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axi_burst_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [63:0] addr, input logic [7:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    #1;
    chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
    #1;
    chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input int aw_wait,
                          input logic toggle, input logic bid, input logic [1:0] bresp,
                          input logic [1:0] exp);
    int sent;
    int cyc;
    logic rdy;
    issue(1'b1, addr, len);
    for (int i = 0; i <= aw_wait; i++) begin
      bus.aw_ready = (i == aw_wait);
      #1;
      chk("aw_valid", 64'(bus.aw_valid), 64'd1);
      chk("aw_addr", bus.aw_addr, addr);
      chk("aw_len", 64'(bus.aw_len), 64'(len));
      if (i == 0) begin
        chk("aw_size", 64'(bus.aw_size), 64'd3);
        chk("aw_burst", 64'(bus.aw_burst), 64'd1);
        chk("aw_cache", 64'(bus.aw_cache), 64'd3);
        chk("aw_id_prot", 64'({bus.aw_id, bus.aw_prot, bus.aw_qos, bus.aw_region}), 64'd0);
      end
      tick();
    end
    bus.aw_ready = 1'b0;
    #1;
    chk("aw_drop", 64'(bus.aw_valid), 64'd0);
    sent = 0;
    cyc  = 0;
    while (sent <= int'(len) && cyc < 1000) begin
      rdy = toggle ? cyc[0] : 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = addr + 64'(sent);
      bus.w_ready  = rdy;
      #1;
      chk("w_valid", 64'(bus.w_valid), 64'd1);
      chk("w_data", bus.w_data, addr + 64'(sent));
      chk("w_strb", 64'(bus.w_strb), 64'hFF);
      chk("w_last", 64'(bus.w_last), 64'(sent == int'(len)));
      chk("wr_ready", 64'(bus.wr_ready), 64'(rdy));
      if (rdy) sent++;
      cyc++;
      tick();
    end
    chk("w_beats", 64'(sent), 64'(int'(len) + 1));
    #1;
    chk("w_valid_in_b", 64'(bus.w_valid), 64'd0);
    chk("b_ready", 64'(bus.b_ready), 64'd1);
    bus.wr_valid = 1'b0;
    bus.w_ready  = 1'b0;
    bus.b_valid  = 1'b1;
    bus.b_id     = bid;
    bus.b_resp   = bresp;
    tick();
    bus.b_valid = 1'b0;
    bus.b_id    = 1'b0;
    bus.b_resp  = 2'b00;
    #1;
    chk("wr_done", 64'(bus.done), 64'd1);
    chk("wr_done_resp", 64'(bus.done_resp), 64'(exp));
    chk("b_ready_done", 64'(bus.b_ready), 64'd0);
    tick();
    chk("wr_done_pulse", 64'(bus.done), 64'd0);
    chk("wr_back_idle", 64'(bus.cmd_ready), 64'd1);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input int ar_wait,
                         input int stall_at, input int stalls, input logic [7:0] rv,
                         input int slast, input logic [1:0] exp);
    int sent;
    int cyc;
    int st;
    int n;
    logic rdy;
    issue(1'b0, addr, len);
    for (int i = 0; i <= ar_wait; i++) begin
      bus.ar_ready = (i == ar_wait);
      #1;
      chk("ar_valid", 64'(bus.ar_valid), 64'd1);
      chk("ar_addr", bus.ar_addr, addr);
      chk("ar_len", 64'(bus.ar_len), 64'(len));
      if (i == 0) begin
        chk("ar_size", 64'(bus.ar_size), 64'd3);
        chk("ar_burst", 64'(bus.ar_burst), 64'd1);
        chk("ar_cache", 64'(bus.ar_cache), 64'd3);
      end
      tick();
    end
    bus.ar_ready = 1'b0;
    #1;
    chk("ar_drop", 64'(bus.ar_valid), 64'd0);
    n    = (slast < int'(len)) ? slast : int'(len);
    sent = 0;
    cyc  = 0;
    st   = stalls;
    while (sent <= n && cyc < 1000) begin
      rdy = !((sent == stall_at) && (st > 0));
      bus.r_valid  = 1'b1;
      bus.r_data   = ~addr + 64'(sent);
      bus.r_resp   = (sent < 4) ? rv[2*sent +: 2] : 2'b00;
      bus.r_last   = (sent == slast);
      bus.rd_ready = rdy;
      #1;
      chk("rd_valid", 64'(bus.rd_valid), 64'd1);
      chk("rd_data", bus.rd_data, ~addr + 64'(sent));
      chk("rd_last", 64'(bus.rd_last), 64'(sent == slast));
      chk("r_ready", 64'(bus.r_ready), 64'(rdy));
      if (rdy) sent++;
      else st--;
      cyc++;
      tick();
    end
    chk("r_beats", 64'(sent), 64'(n + 1));
    bus.r_last = 1'b0;
    bus.r_resp = 2'b00;
    #1;
    chk("rd_valid_in_done", 64'(bus.rd_valid), 64'd0);
    chk("rd_done", 64'(bus.done), 64'd1);
    chk("rd_done_resp", 64'(bus.done_resp), 64'(exp));
    bus.r_valid  = 1'b0;
    bus.rd_ready = 1'b0;
    tick();
    chk("rd_done_pulse", 64'(bus.done), 64'd0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_data = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
    bus.b_resp = '0; bus.b_id = '0; bus.b_valid = 1'b0;
    bus.r_id = '0; bus.r_data = '0; bus.r_resp = '0; bus.r_last = 1'b0; bus.r_valid = 1'b0;

    // reset state
    #12;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_valids", 64'({bus.aw_valid, bus.ar_valid, bus.w_valid, bus.rd_valid}), 64'd0);
    chk("rst_readys", 64'({bus.b_ready, bus.r_ready, bus.wr_ready}), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_addr", bus.aw_addr, 64'd0);
    chk("rst_len", 64'(bus.aw_len), 64'd0);
    rst = 1'b1;
    tick();

    // basic write, basic single-beat read
    do_write(64'h1000, 8'd3, 0, 1'b0, 1'b0, 2'b00, 2'b00);
    do_read(64'h2000, 8'd0, 0, -1, 0, 8'h00, 0, 2'b00);
    // backpressure
    do_write(64'h3000, 8'd3, 5, 1'b1, 1'b0, 2'b00, 2'b00);
    do_read(64'h4000, 8'd3, 2, 1, 3, 8'h00, 3, 2'b00);
    // error merging
    do_read(64'h5000, 8'd3, 0, -1, 0, 8'h20, 3, 2'b10);
    do_read(64'h5100, 8'd3, 0, -1, 0, 8'h00, 1, 2'b10);
    do_write(64'h5200, 8'd1, 0, 1'b0, 1'b1, 2'b00, 2'b10);
    do_read(64'h5300, 8'd1, 0, -1, 0, 8'h01, 1, 2'b01);
    do_read(64'h5400, 8'd1, 0, -1, 0, 8'h00, 5, 2'b10);
    do_write(64'h5500, 8'd0, 1, 1'b0, 1'b0, 2'b11, 2'b11);
    // longest burst: 256 beats
    do_write(64'h8000, 8'd255, 0, 1'b0, 1'b0, 2'b00, 2'b00);

    // reset in the middle of the write data phase
    issue(1'b1, 64'h6000, 8'd3);
    bus.aw_ready = 1'b1;
    tick();
    bus.aw_ready = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 64'h6000;
    bus.w_ready  = 1'b1;
    tick();
    chk("mid_w_valid", 64'(bus.w_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_w_valid", 64'(bus.w_valid), 64'd0);
    chk("mid_rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("mid_rst_ax_valid", 64'({bus.aw_valid, bus.ar_valid}), 64'd0);
    chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    bus.w_ready  = 1'b0;
    tick();
    chk("post_rst_no_done", 64'(bus.done), 64'd0);
    do_write(64'h7000, 8'd1, 0, 1'b0, 1'b0, 2'b00, 2'b00);
    do_read(64'h7100, 8'd2, 1, 0, 1, 8'h00, 2, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI4 initiator for the on-chip memory responder. Issues one INCR burst per command: a write via AW/W/B or a read via AR/R.
- Sits between a simple command/data-stream client (DMA engine, test driver) and the memory's AXI slave ports.
- One outstanding transaction at a time. Address phase strictly precedes data phase.

Parameters:
- DATA_WIDTH, 64, AXI data width; strobe width is DATA_WIDTH/8.
- ADDRESS_WIDTH, 64, AXI address width.
- ID_WIDTH, 1, AXI ID width; all transactions use ID 0.
- TIMEOUT, 1024, watchdog limit in cycles (optional feature only).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command request
- cmd_ready  output  1  high in IDLE only
- cmd_write  input  1  1=write burst, 0=read burst
- cmd_addr  input  ADDRESS_WIDTH  burst start address
- cmd_len  input  8  beats minus one (AXI len)
- wr_data  input  DATA_WIDTH  write beat data
- wr_valid  input  1  write beat available
- wr_ready  output  1  write beat consumed
- rd_data  output  DATA_WIDTH  read beat data
- rd_valid  output  1  read beat available
- rd_last  output  1  final read beat
- rd_ready  input  1  client accepts read beat
- done  output  1  one-cycle pulse, transaction complete
- done_resp  output  2  merged response, valid with done
- aw_id/ar_id  output  ID_WIDTH  constant 0
- aw_addr/ar_addr  output  ADDRESS_WIDTH  latched cmd_addr
- aw_len/ar_len  output  8  latched cmd_len
- aw_size/ar_size  output  3  log2(DATA_WIDTH/8) (3 at default)
- aw_burst/ar_burst  output  2  2'b01 INCR
- aw_cache/ar_cache  output  4  4'b0011
- aw_prot/ar_prot, aw_qos/ar_qos, aw_region/ar_region  output  3/4/4  zero
- aw_valid/ar_valid  output  1  address valid
- aw_ready/ar_ready  input  1  address accepted
- w_data  output  DATA_WIDTH  = wr_data
- w_strb  output  DATA_WIDTH/8  all ones
- w_last  output  1  final write beat
- w_valid  output  1  write valid
- w_ready  input  1  slave accepts beat
- b_resp  input  2  write response
- b_id  input  ID_WIDTH  response ID
- b_valid  input  1  response valid
- b_ready  output  1  high in WR_B
- r_id  input  ID_WIDTH  read ID
- r_data  input  DATA_WIDTH  read data
- r_resp  input  2  read response
- r_last  input  1  slave last beat
- r_valid  input  1  read valid
- r_ready  output  1  = rd_ready in RD_R

Behaviour:
- FSM states: IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, DONE.
- Reset (rst low, asynchronous): state IDLE; aw_valid/ar_valid/done/beat counter/accumulated resp = 0; latched addr/len = 0. Comb outputs follow state: cmd_ready=1, w_valid/wr_ready/b_ready/r_ready/rd_valid = 0. Reset mid-burst abandons the transaction; no completion is reported.
- IDLE: cmd_valid&cmd_ready latches addr, len, write. Next cycle: WR_AW with aw_valid=1, or RD_AR with ar_valid=1.
- WR_AW/RD_AR: valid and all A-channel fields held stable until ready. On valid&ready, valid drops next cycle; go to WR_W/RD_R. Beat counter and accumulated resp cleared.
- WR_W: w_valid=wr_valid; wr_ready=w_ready; w_last=(beat==len). Beat counter increments on w_valid&w_ready. The last-beat handshake moves to WR_B.
- WR_B: b_ready=1. On b_valid: resp=b_resp, forced to 2'b10 if b_id!=0; go to DONE.
- RD_R: rd_valid=r_valid; r_ready=rd_ready; rd_data=r_data; rd_last=r_last.
  - Each handshake: beat++; accumulated resp = max(acc, r_resp).
  - r_last arriving with beat!=len, or beat==len without r_last: acc forced to at least 2'b10.
  - The handshake carrying r_last or beat==len moves to DONE.
- DONE: done=1 for exactly one cycle with done_resp; then IDLE. cmd_ready is 0 during DONE, so a back-to-back command is accepted the cycle after.
- Beat counter is 9 bits; len=255 gives 256 beats with no wrap.
- 4KB boundary crossing is not checked; avoiding it is the client's responsibility.

Optional Feature:
- Macro AXI_BURST_MASTER_TIMEOUT_EN.
- Defined: a cycle counter runs in WR_AW/WR_W/WR_B/RD_AR/RD_R and clears on every channel handshake. Reaching TIMEOUT forces DONE with done_resp=2'b11 and drops all valids/readys. Protocol abandonment is accepted for debug.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Write len=3, addr 0x1000, slave ready always: aw_valid 1 cycle; 4 W beats with w_last on the 4th; b_resp 00 gives done with done_resp 00.
- Read len=0, r_resp 00, r_last=1: single rd_valid beat with rd_last=1; done_resp 00.
- Backpressure: aw_ready delayed 5 cycles, w_ready toggling, rd_ready low 3 cycles: A-channel fields stable; no beat lost or duplicated; correct counts.
- Errors: read with beat 2 r_resp=2'b10 gives done_resp 10; read with r_last early on beat 1 of len=3 gives done_resp 10; write with b_id=1 gives 10.
- Reset asserted mid-WR_W: all valids 0 immediately; next command accepted normally after release.
- With AXI_BURST_MASTER_TIMEOUT_EN, TIMEOUT=16, b_valid never asserted: done at cycle 16 of WR_B with done_resp 11.
